// File: rtl/cpu_execute_stage.sv
// Issue/execute/writeback stage in front of a 2-read/1-write register file.
// 4-bit signed saturating ALU, writeback forwarding, iterative 4-cycle multiply.
module cpu_execute_stage #(
  parameter int NUMBER_OF_REGISTERS = 256,
  parameter int AW = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 instruction_valid_in,
  output logic                 instruction_ready_out,
  input  logic [2:0]           opcode_in,
  input  logic [AW-1:0]        destination_register_address_in,
  input  logic [AW-1:0]        source_register_address1_in,
  input  logic [AW-1:0]        source_register_address2_in,
  input  logic signed [3:0]    immediate_in,
  output logic [AW-1:0]        read_register_address1_out,
  output logic [AW-1:0]        read_register_address2_out,
  input  logic signed [3:0]    read_data1_in,
  input  logic signed [3:0]    read_data2_in,
  output logic                 write_enable_out,
  output logic [AW-1:0]        write_register_address_out,
  output logic signed [3:0]    write_data_out,
  output logic                 pipeline_empty_out
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [1:0] {
    EMPTY,
    SINGLE,
    MUL_BUSY
  } issue_state_t;

  issue_state_t state, next_state;
  logic [1:0]   counter, next_counter;
  logic         accept;
  logic         complete;

  logic [2:0]        issue_opcode;
  logic [AW-1:0]     issue_rd;
  logic [AW-1:0]     issue_rs1;
  logic [AW-1:0]     issue_rs2;
  logic signed [3:0] issue_imm;

  logic              wb_valid;
  logic              wb_write;
  logic [AW-1:0]     wb_rd;
  logic signed [3:0] wb_data;

  logic              forward1, forward2;
  logic signed [3:0] operand1, operand2;
  logic signed [4:0] add_sum, sub_diff, addi_sum;
  logic signed [3:0] result;

  logic signed [7:0] mul_mcand;
  logic [3:0]        mul_mplier;
  logic signed [7:0] mul_acc;
  logic signed [7:0] mul_cur_mcand;
  logic [3:0]        mul_cur_mplier;
  logic signed [7:0] mul_cur_acc;
  logic signed [7:0] mul_term;
  logic signed [7:0] mul_next_acc;

  function automatic logic signed [3:0] saturate8(input logic signed [7:0] value);
    if (value > 8'sd7) begin
      return 4'sd7;
    end else if (value < 8'shF8) begin
      return 4'sb1000;
    end else begin
      return value[3:0];
    end
  endfunction

  function automatic logic signed [3:0] saturate5(input logic signed [4:0] value);
    return saturate8({{3{value[4]}}, value});
  endfunction

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state   <= EMPTY;
      counter <= 2'd0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // A finishing instruction frees the issue slot in the same cycle, so a new one can load behind it.
  always_comb begin
    next_state            = state;
    next_counter          = counter;
    complete              = 1'b0;
    instruction_ready_out = 1'b0;
    accept                = 1'b0;
    case (state)
      EMPTY: begin
        instruction_ready_out = !reset_in;
      end
      SINGLE: begin
        complete              = 1'b1;
        instruction_ready_out = !reset_in;
        next_state            = EMPTY;
      end
      MUL_BUSY: begin
        if (counter == 2'd3) begin
          complete              = 1'b1;
          instruction_ready_out = !reset_in;
          next_state            = EMPTY;
        end else begin
          next_counter = counter + 2'd1;
        end
      end
      default: begin
        next_state = EMPTY;
      end
    endcase
    accept = instruction_valid_in && instruction_ready_out;
    if (accept) begin
      next_state   = (opcode_in == OP_MUL) ? MUL_BUSY : SINGLE;
      next_counter = 2'd0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      issue_opcode <= OP_NOP;
      issue_rd     <= '0;
      issue_rs1    <= '0;
      issue_rs2    <= '0;
      issue_imm    <= '0;
    end else if (accept) begin
      issue_opcode <= opcode_in;
      issue_rd     <= destination_register_address_in;
      issue_rs1    <= source_register_address1_in;
      issue_rs2    <= source_register_address2_in;
      issue_imm    <= immediate_in;
    end
  end

  // Register 0 is never written, so it must never be forwarded either.
  assign forward1 = wb_valid && wb_write && (wb_rd != '0) && (wb_rd == issue_rs1);
  assign forward2 = wb_valid && wb_write && (wb_rd != '0) && (wb_rd == issue_rs2);
  assign operand1 = forward1 ? wb_data : read_data1_in;
  assign operand2 = forward2 ? wb_data : read_data2_in;

  assign add_sum  = {operand1[3], operand1} + {operand2[3], operand2};
  assign sub_diff = {operand1[3], operand1} - {operand2[3], operand2};
  assign addi_sum = {operand1[3], operand1} + {issue_imm[3], issue_imm};

  // Multiplier bit 3 carries weight -8, so the last partial product is subtracted.
  always_comb begin
    mul_cur_mcand  = (counter == 2'd0) ? {{4{operand1[3]}}, operand1} : mul_mcand;
    mul_cur_mplier = (counter == 2'd0) ? operand2 : mul_mplier;
    mul_cur_acc    = (counter == 2'd0) ? 8'sd0 : mul_acc;
    mul_term       = mul_cur_mplier[counter] ? (mul_cur_mcand << counter) : 8'sd0;
    mul_next_acc   = (counter == 2'd3) ? (mul_cur_acc - mul_term) : (mul_cur_acc + mul_term);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
    end else if (state == MUL_BUSY) begin
      if (counter == 2'd0) begin
        mul_mcand  <= mul_cur_mcand;
        mul_mplier <= mul_cur_mplier;
      end
      mul_acc <= mul_next_acc;
    end
  end

  always_comb begin
    result = '0;
    case (issue_opcode)
      OP_ADD:  result = saturate5(add_sum);
      OP_SUB:  result = saturate5(sub_diff);
      OP_AND:  result = operand1 & operand2;
      OP_OR:   result = operand1 | operand2;
      OP_XOR:  result = operand1 ^ operand2;
      OP_ADDI: result = saturate5(addi_sum);
      OP_MUL:  result = saturate8(mul_next_acc);
      default: result = '0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      wb_valid <= 1'b0;
      wb_write <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (complete) begin
      wb_valid <= 1'b1;
      wb_write <= (issue_opcode != OP_NOP);
      wb_rd    <= issue_rd;
      wb_data  <= result;
    end else begin
      wb_valid <= 1'b0;
      wb_write <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end
  end

  // Outputs are forced quiet while reset is high, even before the state registers clear.
  assign read_register_address1_out = (reset_in || state == EMPTY) ? '0 : issue_rs1;
  assign read_register_address2_out = (reset_in || state == EMPTY) ? '0 : issue_rs2;
  assign write_enable_out           = !reset_in && wb_valid && wb_write && (wb_rd != '0);
  assign write_register_address_out = reset_in ? '0 : wb_rd;
  assign write_data_out             = reset_in ? '0 : wb_data;
  assign pipeline_empty_out         = reset_in || (state == EMPTY && !wb_valid);

endmodule
